// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one-at-a-time word reads to
// instruction memory and queues returned words in order for the datapath.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_count,
  output logic [1:0]  dbg_state
);

  // Handshakes: a request is accepted in a cycle where imem_req and imem_ack are
  // both high, and its single response is the next imem_rvalid pulse. The datapath
  // takes the head word in any cycle where inst_valid and inst_ready are both high;
  // inst_valid never depends combinationally on inst_ready.

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_addr_q;
  logic [31:0]   q_data_q [QUEUE_DEPTH];
  logic [31:0]   q_pc_q   [QUEUE_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] wait_occ;
  logic [31:0]   fetch_count_q;
  logic          accept, push, pop;

  assign accept   = (state_q == S_REQ) && imem_ack;
  assign pop      = inst_valid && inst_ready;
  assign wait_occ = count_q + CW'(1) - CW'(pop);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      case (state_q)
        S_REQ:          state_d = accept ? S_DROP : S_REQ;
        S_WAIT, S_DROP: state_d = imem_rvalid ? S_REQ : S_DROP;
        default:        state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_IDLE: if (count_q < DEPTH_C) state_d = S_REQ;
        S_REQ: begin
          if (imem_ack) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            push    = 1'b1;
            state_d = (wait_occ < DEPTH_C) ? S_REQ : S_IDLE;
          end
        end
        default: if (imem_rvalid) state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      fetch_pc_q    <= RESET_PC;
      req_addr_q    <= 32'd0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      fetch_count_q <= 32'd0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_data_q[i] <= 32'd0;
        q_pc_q[i]   <= 32'd0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if (accept) req_addr_q <= fetch_pc_q;
      if (pop) fetch_count_q <= fetch_count_q + 32'd1;
      // A redirect empties the queue outright; the pop above is still counted.
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          q_data_q[wr_ptr_q] <= imem_rdata;
          q_pc_q[wr_ptr_q]   <= req_addr_q;
          wr_ptr_q           <= wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

  assign imem_req      = (state_q == S_REQ);
  assign imem_addr     = fetch_pc_q;
  assign inst_valid    = (count_q != '0);
  assign inst_data     = q_data_q[rd_ptr_q];
  assign inst_pc       = q_pc_q[rd_ptr_q];
  assign inst_pc_plus4 = q_pc_q[rd_ptr_q] + 32'd4;
  assign fetch_count   = fetch_count_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: hand-timed imem responses, redirects and resets
// with every expected value written out by hand.
module tb_fetch_unit;

  localparam int QD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_count;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(QD)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .inst_pc_plus4 (inst_pc_plus4),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .fetch_count   (fetch_count),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // A push into a full queue must never happen.
  always @(negedge clk) begin
    if (rst && dut.push)
      check_eq("push_not_full", {31'b0, (int'(dut.count_q) < QD)}, 32'd1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_ack    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    inst_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_req",   imem_req,      32'd0);
    check_eq("rst_addr",  imem_addr,     32'h0000_0000);
    check_eq("rst_valid", inst_valid,    32'd0);
    check_eq("rst_data",  inst_data,     32'd0);
    check_eq("rst_pc",    inst_pc,       32'd0);
    check_eq("rst_pc4",   inst_pc_plus4, 32'd4);
    check_eq("rst_count", fetch_count,   32'd0);
    check_eq("rst_state", dbg_state,     32'd0);
  endtask

  // Leaves rst released just after a rising edge; the next edge moves IDLE->REQ.
  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    tick();
    tick();
    check_reset_outputs();
    rst = 1'b1;
    check_eq("idle_after_rel", imem_req, 32'd0);
  endtask

  // Expects the DUT in REQ; acks at once and returns the word one cycle later.
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data);
    check_eq("req_hi",   imem_req,  32'd1);
    check_eq("req_addr", imem_addr, addr);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    check_eq("req_lo_wait", imem_req, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
  endtask

  task automatic check_head(input logic [31:0] pc, input logic [31:0] pc4, input logic [31:0] data);
    check_eq("head_valid", inst_valid,    32'd1);
    check_eq("head_pc",    inst_pc,       pc);
    check_eq("head_pc4",   inst_pc_plus4, pc4);
    check_eq("head_data",  inst_data,     data);
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    #1;
    check_reset_outputs();

    // Streaming fetch with a ready datapath.
    do_reset();
    inst_ready = 1'b1;
    tick();
    fetch_one(32'h0, 32'h2008_0005);
    check_head(32'h0, 32'h4, 32'h2008_0005);
    check_eq("cnt0", fetch_count, 32'd0);
    fetch_one(32'h4, 32'h2008_0006);
    check_head(32'h4, 32'h8, 32'h2008_0006);
    check_eq("cnt1", fetch_count, 32'd1);
    fetch_one(32'h8, 32'h2008_0007);
    check_head(32'h8, 32'hC, 32'h2008_0007);
    check_eq("cnt2", fetch_count, 32'd2);

    // Backpressure fills the two-entry queue, then drains.
    do_reset();
    tick();
    fetch_one(32'h0, 32'hA000_0000);
    fetch_one(32'h4, 32'hA000_0004);
    check_head(32'h0, 32'h4, 32'hA000_0000);
    for (int i = 0; i < 3; i++) begin
      check_eq("full_no_req", imem_req, 32'd0);
      tick();
    end
    check_eq("full_no_req_end", imem_req, 32'd0);
    inst_ready = 1'b1;
    tick();
    check_head(32'h4, 32'h8, 32'hA000_0004);
    check_eq("drain_still_idle", imem_req, 32'd0);
    check_eq("drain_cnt1", fetch_count, 32'd1);
    tick();
    check_eq("drain_empty", inst_valid, 32'd0);
    check_eq("drain_cnt2", fetch_count, 32'd2);
    fetch_one(32'h8, 32'hA000_0008);
    check_head(32'h8, 32'hC, 32'hA000_0008);

    // Redirect while WAIT; stale response three cycles later.
    do_reset();
    inst_ready = 1'b1;
    tick();
    imem_ack = 1'b1;
    tick();
    imem_ack    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0043;
    tick();
    redirect = 1'b0;
    check_eq("wait_redir_state", dbg_state, 32'd3);
    check_eq("wait_redir_req",   imem_req,  32'd0);
    tick();
    check_eq("drop_valid1", inst_valid, 32'd0);
    tick();
    check_eq("drop_valid2", inst_valid, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    check_eq("stale_dropped", inst_valid, 32'd0);
    check_eq("after_drop_state", dbg_state, 32'd1);
    fetch_one(32'h40, 32'h2409_0001);
    check_head(32'h40, 32'h44, 32'h2409_0001);

    // Redirect in the ack cycle goes through DROP.
    do_reset();
    inst_ready = 1'b1;
    tick();
    imem_ack    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    imem_ack = 1'b0;
    redirect = 1'b0;
    check_eq("ack_redir_state", dbg_state, 32'd3);
    check_eq("ack_redir_addr",  imem_addr, 32'h100);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0000;
    tick();
    imem_rvalid = 1'b0;
    check_eq("ack_redir_drop_valid", inst_valid, 32'd0);
    fetch_one(32'h100, 32'h1111_0100);
    check_head(32'h100, 32'h104, 32'h1111_0100);
    fetch_one(32'h104, 32'h1111_0104);
    check_head(32'h104, 32'h108, 32'h1111_0104);
    check_eq("ack_redir_cnt", fetch_count, 32'd1);

    // Redirect together with rvalid, popping the head in the same cycle.
    inst_ready = 1'b0;
    imem_ack   = 1'b1;
    tick();
    imem_ack = 1'b0;
    check_head(32'h104, 32'h108, 32'h1111_0104);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h2222_0108;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    inst_ready  = 1'b1;
    tick();
    imem_rvalid = 1'b0;
    redirect    = 1'b0;
    check_eq("rv_redir_empty", inst_valid,  32'd0);
    check_eq("rv_redir_state", dbg_state,   32'd1);
    check_eq("rv_redir_cnt",   fetch_count, 32'd2);
    fetch_one(32'h200, 32'h3333_0200);
    check_head(32'h200, 32'h204, 32'h3333_0200);

    // Redirect to the top word; address and pc+4 wrap.
    do_reset();
    inst_ready = 1'b1;
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    fetch_one(32'hFFFF_FFFC, 32'h4444_0000);
    check_head(32'hFFFF_FFFC, 32'h0, 32'h4444_0000);
    fetch_one(32'h0, 32'h4444_0004);
    check_head(32'h0, 32'h4, 32'h4444_0004);

    // Asynchronous reset while WAIT, then a late response.
    do_reset();
    inst_ready = 1'b1;
    tick();
    fetch_one(32'h0, 32'h5555_0000);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    check_eq("pre_rst_wait", dbg_state, 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs();
    tick();
    rst         = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    check_eq("late_rv_valid1", inst_valid, 32'd0);
    check_eq("late_rv_addr1",  imem_addr,  32'h0);
    tick();
    imem_rvalid = 1'b0;
    check_eq("late_rv_valid2", inst_valid, 32'd0);
    fetch_one(32'h0, 32'h6666_0000);
    check_head(32'h0, 32'h4, 32'h6666_0000);
    check_eq("late_rv_cnt", fetch_count, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
